uart_tx_arbiter: RTL and testbench

- Shares the single UART byte transmitter between NUM_REQ byte-stream requesters, e.g. the button/LED logic and a status reporter.
- Arbitration is round-robin with per-message locking, so multi-byte messages are never interleaved on UART_TX.
- Sits between the requesters and the transmitter core inside the uart top level, in the CLOCK_50 domain.

---
 rtl/uart_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 158 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, ACK watchdog
// length and a constant-width helper.
package uart_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE      = 2'd0;
  localparam state_t WAIT_ACK  = 2'd1;
  localparam state_t WAIT_DONE = 2'd2;

  // Cycles without tx_busy after tx_start before the byte is assumed sent.
  localparam int ACK_TIMEOUT = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request strictly after the
// last-served pointer, wrapping to index 0.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  logic [N-1:0] above_ptr;
  logic [N-1:0] upper;
  logic [N-1:0] pool;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign above_ptr[gi] = (W'(gi) > ptr_i);
    end
  endgenerate

  // Requests above the pointer win; otherwise wrap and take the lowest one.
  assign upper = req_i & above_ptr;
  assign pool  = (|upper) ? upper : req_i;
  assign any_o = |req_i;

  always_comb begin
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (pool[k]) begin
        idx_o = W'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter between NUM_REQ requesters with round-robin
// arbitration and per-message locking, plus a stall timeout that revokes a lock.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1000000,
  parameter int ID_W         = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 tx_start_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_busy_i,
  output logic [ID_W-1:0]      grant_id_o,
  output logic                 locked_o,
  output logic                 timeout_evt_o
);

  localparam int LCNT_W = clog2(LOCK_TIMEOUT);
  localparam int ACNT_W = clog2(ACK_TIMEOUT);

  state_t            state_q, state_d;
  logic              run_q;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic              locked_q, locked_d;
  logic              tevt_q, tevt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic [ACNT_W-1:0] acnt_q, acnt_d;

  logic [ID_W-1:0]   rr_idx;
  logic              rr_any;
  logic [ID_W-1:0]   win_idx;
  logic              win_valid;
  logic [7:0]        win_data;
  logic              win_last;
  logic              accept;
  logic              stall;

  rr_pick #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_pick (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .idx_o (rr_idx),
    .any_o (rr_any)
  );

  // A held lock pins the candidate to the locked requester.
  assign win_idx   = locked_q ? grant_q : rr_idx;
  assign win_valid = locked_q ? req_valid_i[grant_q] : rr_any;
  assign win_data  = req_data_i[{win_idx, 3'b000} +: 8];
  assign win_last  = req_last_i[win_idx];

  // run_q keeps ready low while reset is asserted.
  assign accept = run_q && (state_q == IDLE) && win_valid && !tx_busy_i;
  assign stall  = (state_q == IDLE) && locked_q && !req_valid_i[grant_q];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready_o[gi] = accept && (win_idx == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    locked_d   = locked_q;
    tevt_d     = 1'b0;
    ptr_d      = ptr_q;
    lcnt_d     = lcnt_q;
    acnt_d     = acnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tx_start_d = 1'b1;
          tx_data_d  = win_data;
          grant_d    = win_idx;
          state_d    = WAIT_ACK;
          acnt_d     = '0;
          lcnt_d     = '0;
          locked_d   = !win_last;
          if (win_last) begin
            ptr_d = win_idx;
          end
        end else if (stall) begin
          if (lcnt_q == LCNT_W'(LOCK_TIMEOUT - 1)) begin
            locked_d = 1'b0;
            tevt_d   = 1'b1;
            ptr_d    = grant_q;
            lcnt_d   = '0;
          end else begin
            lcnt_d = lcnt_q + 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        // A transmitter that never raises busy must not hang the arbiter.
        if (tx_busy_i) begin
          state_d = WAIT_DONE;
        end else if (acnt_q == ACNT_W'(ACK_TIMEOUT - 1)) begin
          state_d = IDLE;
        end else begin
          acnt_d = acnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      grant_q    <= '0;
      locked_q   <= 1'b0;
      tevt_q     <= 1'b0;
      ptr_q      <= ID_W'(NUM_REQ - 1);
      lcnt_q     <= '0;
      acnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      locked_q   <= locked_d;
      tevt_q     <= tevt_d;
      ptr_q      <= ptr_d;
      lcnt_q     <= lcnt_d;
      acnt_q     <= acnt_d;
    end
  end

  assign tx_start_o    = tx_start_q;
  assign tx_data_o     = tx_data_q;
  assign grant_id_o    = grant_q;
  assign locked_o      = locked_q;
  assign timeout_evt_o = tevt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a message-level round-robin model
// predicts the byte order, a monitor checks every tx_start against it.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int LT  = 50;
  localparam int IDW = 2;
  localparam int ACK = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy = 1'b0;
  logic [IDW-1:0] grant_id;
  logic           locked;
  logic           timeout_evt;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .LOCK_TIMEOUT (LT),
    .ID_W         (IDW)
  ) dut (
    .clk_i         (clk),
    .reset_ni      (rst_n),
    .req_valid_i   (req_valid),
    .req_data_i    (req_data),
    .req_last_i    (req_last),
    .req_ready_o   (req_ready),
    .tx_start_o    (tx_start),
    .tx_data_o     (tx_data),
    .tx_busy_i     (tx_busy),
    .grant_id_o    (grant_id),
    .locked_o      (locked),
    .timeout_evt_o (timeout_evt)
  );

  typedef struct {
    int         lane;
    logic [7:0] data;
    logic       last;
  } exp_t;

  int         n_tests = 0;
  int         n_fail = 0;
  exp_t       exp_q[$];
  logic [8:0] stage_q[N][$];
  logic [8:0] lane_q[N][$];
  logic [N-1:0] acc = '0;
  int         model_ptr = N - 1;
  int         cyc = 0;
  int         start_cyc[$];
  int         tevt_cyc[$];
  int         fall_cyc[$];
  logic [7:0] last_started = 8'h00;
  logic       busy_prev = 1'b0;
  logic       tx_dead = 1'b0;
  logic       tx_hold = 1'b0;
  int         tx_dur = 3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
    end
  endtask

  task automatic add_byte(input int lane, input logic [7:0] data, input logic last);
    stage_q[lane].push_back({last, data});
  endtask

  // Reference: serve whole messages round-robin starting after the last served lane.
  task automatic launch();
    logic [8:0] w;
    exp_t       e;
    int         lane;
    int         c;
    forever begin
      lane = -1;
      for (int k = 1; k <= N; k++) begin
        c = (model_ptr + k) % N;
        if (lane < 0 && stage_q[c].size() > 0) lane = c;
      end
      if (lane < 0) break;
      do begin
        w = stage_q[lane].pop_front();
        lane_q[lane].push_back(w);
        e.lane = lane;
        e.data = w[7:0];
        e.last = w[8];
        exp_q.push_back(e);
      end while (!w[8] && stage_q[lane].size() > 0);
      model_ptr = lane;
    end
  endtask

  function automatic bit lanes_pending();
    for (int i = 0; i < N; i++) begin
      if (lane_q[i].size() > 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || lanes_pending() || tx_busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_drain: %0d bytes still expected after %0d cycles, required 0", name, exp_q.size(), budget);
      exp_q.delete();
      for (int i = 0; i < N; i++) lane_q[i].delete();
    end
    repeat (8) @(negedge clk);
  endtask

  // Monitor: all output sampling happens on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        last_started = 8'h00;
      end else begin
        check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
        check("ready_needs_valid", 32'(req_ready & ~req_valid), 32'd0);
        acc = acc | req_ready;
        if (tx_busy) check("tx_data_hold", 32'(tx_data), 32'(last_started));
        if (tx_start) begin
          start_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_tx_start: got byte 0x%0h from lane %0d, required no start", tx_data, grant_id);
          end else begin
            e = exp_q.pop_front();
            $display("[TB] tx byte 0x%02h lane %0d (expected 0x%02h lane %0d)", tx_data, grant_id, e.data, e.lane);
            check("tx_data", 32'(tx_data), 32'(e.data));
            check("grant_id", 32'(grant_id), 32'(e.lane));
            check("locked_after_byte", 32'(locked), 32'(!e.last));
          end
          last_started = tx_data;
        end
        if (timeout_evt) begin
          tevt_cyc.push_back(cyc);
          check("locked_at_timeout", 32'(locked), 32'd0);
        end
        if (busy_prev && !tx_busy) fall_cyc.push_back(cyc);
      end
      busy_prev = tx_busy;
    end
  end

  // Requester drivers: present the head of each lane queue, pop on acceptance.
  initial begin
    logic [8:0] w;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && lane_q[i].size() > 0) w = lane_q[i].pop_front();
      end
      acc = '0;
      for (int i = 0; i < N; i++) begin
        if (lane_q[i].size() > 0) begin
          w = lane_q[i][0];
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = w[7:0];
          req_last[i] = w[8];
        end else begin
          req_valid[i] = 1'b0;
          req_data[8*i +: 8] = 8'($urandom);
          req_last[i] = 1'($urandom);
        end
      end
    end
  end

  // Transmitter: busy rises the cycle after tx_start, falls after tx_dur cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start && !tx_dead) begin
        @(posedge clk);
        #1;
        tx_busy = 1'b1;
        repeat (tx_dur) @(posedge clk);
        while (tx_hold) @(posedge clk);
        #1;
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    int n0;
    int v;
    int k;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_timeout_evt", 32'(timeout_evt), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Round-robin, two passes over all four lanes.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) add_byte(i, 8'h41 + 8'(i), 1'b1);
      launch();
      wait_done("round_robin", 500);
    end

    // Single byte: tx_start one cycle after the valid cycle.
    n0 = start_cyc.size();
    add_byte(0, 8'h30, 1'b1);
    launch();
    @(posedge clk);
    @(negedge clk);
    #1 v = cyc;
    wait_done("single", 200);
    check("single_latency", 32'(start_cyc[n0] - v), 32'd1);

    // Message lock with competing requesters.
    add_byte(1, 8'h48, 1'b0);
    add_byte(1, 8'h49, 1'b0);
    add_byte(1, 8'h0A, 1'b1);
    add_byte(0, 8'h61, 1'b1);
    add_byte(2, 8'h63, 1'b1);
    launch();
    wait_done("msg_lock", 500);

    // Lock timeout: lane 3 stalls mid-message, lane 0 is held off until revoke.
    tevt_cyc.delete();
    fall_cyc.delete();
    n0 = start_cyc.size();
    add_byte(3, 8'h58, 1'b0);
    add_byte(0, 8'h31, 1'b1);
    launch();
    wait_done("lock_timeout", 600);
    check("timeout_evt_count", 32'(tevt_cyc.size()), 32'd1);
    if (tevt_cyc.size() > 0 && fall_cyc.size() > 0 && start_cyc.size() >= n0 + 2) begin
      // busy low is sampled at the end of the fall cycle, then LT stalled idle cycles.
      check("timeout_delay", 32'(tevt_cyc[0] - fall_cyc[0]), 32'(LT + 1));
      check("held_off_until_revoke", 32'(start_cyc[n0 + 1] > tevt_cyc[0]), 32'd1);
    end else begin
      check("timeout_observed", 32'd0, 32'd1);
    end

    // Dead transmitter: busy never rises.
    tx_dead = 1'b1;
    n0 = start_cyc.size();
    add_byte(1, 8'h70, 1'b1);
    add_byte(2, 8'h71, 1'b1);
    launch();
    wait_done("dead_tx", 200);
    if (start_cyc.size() >= n0 + 2) check("dead_tx_gap", 32'(start_cyc[n0 + 1] - start_cyc[n0]), 32'(ACK + 1));
    else check("dead_tx_starts", 32'(start_cyc.size() - n0), 32'd2);
    tx_dead = 1'b0;

    // Reset while the transmitter is busy.
    tx_hold = 1'b1;
    add_byte(1, 8'h52, 1'b1);
    launch();
    k = 0;
    while (!tx_busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("busy_before_reset", 32'(tx_busy), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_tx_start", 32'(tx_start), 32'd0);
    check("midrst_tx_data", 32'(tx_data), 32'd0);
    check("midrst_grant_id", 32'(grant_id), 32'd0);
    check("midrst_locked", 32'(locked), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd0);
    model_ptr = N - 1;
    add_byte(2, 8'h53, 1'b1);
    add_byte(0, 8'h54, 1'b1);
    launch();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n0 = start_cyc.size();
    repeat (10) @(negedge clk);
    check("no_start_while_busy", 32'(start_cyc.size() - n0), 32'd0);
    tx_hold = 1'b0;
    wait_done("after_reset", 300);

    // Randomized multi-message rounds.
    for (int r = 0; r < 8; r++) begin
      tx_dur = $urandom_range(1, 5);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1 || i == r % N) begin
          for (int m = 0; m < $urandom_range(1, 2); m++) begin
            v = $urandom_range(1, 3);
            for (int b = 0; b < v; b++) add_byte(i, 8'($urandom), b == v - 1);
          end
        end
      end
      launch();
      wait_done("random", 2000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
